// File: rtl/pwm_ramp_pkg.sv
// Shared types and saturating helpers for the PWM duty ramp controller.
package pwm_ramp_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NUM_CH = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SYNC,
    RAMP_UP,
    HOLD,
    RAMP_DOWN
  } state_t;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = (DATA_W+1)'(a) + (DATA_W+1)'(b);
    return sum[DATA_W] ? '1 : sum[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sat_mul(input logic [DATA_W-1:0] a,
                                                input logic [1:0]        k);
    logic [DATA_W+1:0] prod;
    prod = (DATA_W+2)'(a) * (DATA_W+2)'(k);
    return (|prod[DATA_W+1:DATA_W]) ? '1 : prod[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_wrap_div.sv
// Detects PWM counter wraps and divides them down to one tick every DIV wraps.
module pwm_wrap_div
  import pwm_ramp_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] cnt_q,
  input  logic              clr,
  output logic              wrap,
  output logic              tick
);

  localparam int unsigned DIV_W = 8;

  logic [DATA_W-1:0] prev_q;
  logic [DIV_W-1:0]  div_cnt;

  // Combinational so a duty update lands on the edge that closes the wrap cycle.
  assign wrap = (cnt_q == '0) && (prev_q != '0);
  assign tick = wrap && (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= '0;
      div_cnt <= '0;
    end else begin
      prev_q <= cnt_q;
      if (clr) begin
        div_cnt <= '0;
      end else if (wrap) begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop duty ramp for four phase-shifted PWM channels.
// Define PWM_RAMP_PHASE_EN to produce per-channel start offsets from cfg_phase.
module pwm_ramp_ctrl
  import pwm_ramp_pkg::*;
#(
  parameter int unsigned       STEP_W     = 16,
  parameter int unsigned       DIV        = 1,
  parameter logic [DATA_W-1:0] MAX_PERIOD = 32'd999_999_999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] cfg_period,
  input  logic [DATA_W-1:0] cfg_target,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic [DATA_W-1:0] cfg_phase,
  input  logic [DATA_W-1:0] cnt_q,
  output logic              load,
  output logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] s0,
  output logic [DATA_W-1:0] s1,
  output logic [DATA_W-1:0] s2,
  output logic [DATA_W-1:0] s3,
  output logic [DATA_W-1:0] p0,
  output logic [DATA_W-1:0] p1,
  output logic [DATA_W-1:0] p2,
  output logic [DATA_W-1:0] p3,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_n;
  logic [DATA_W-1:0] duty_q, duty_n;
  logic [DATA_W-1:0] period_q, period_n;
  logic [DATA_W-1:0] target_q, target_n;
  logic [DATA_W-1:0] step_q, step_n;
  logic              done_n;
  logic              wrap, tick;
  logic [DATA_W-1:0] s_q [NUM_CH];
  logic [DATA_W-1:0] p_q [NUM_CH];
  logic [DATA_W-1:0] s_n [NUM_CH];
  logic [DATA_W-1:0] p_n [NUM_CH];
`ifdef PWM_RAMP_PHASE_EN
  logic [DATA_W-1:0] phase_q, phase_n;
`else
  logic              unused_phase;
  assign unused_phase = ^cfg_phase;
`endif

  pwm_wrap_div #(.DIV(DIV)) u_wrap_div (
    .clk     (clk),
    .reset_n (reset_n),
    .cnt_q   (cnt_q),
    .clr     (state_n != state_q),
    .wrap    (wrap),
    .tick    (tick)
  );

  // Next state, duty and latched configuration.
  always_comb begin
    state_n  = state_q;
    duty_n   = duty_q;
    period_n = period_q;
    target_n = target_q;
    step_n   = step_q;
    done_n   = 1'b0;
`ifdef PWM_RAMP_PHASE_EN
    phase_n  = phase_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          period_n = (cfg_period > MAX_PERIOD) ? MAX_PERIOD : cfg_period;
          target_n = ((DATA_W+1)'(cfg_target) > (DATA_W+1)'(period_n) + (DATA_W+1)'(1))
                     ? period_n + DATA_W'(1) : cfg_target;
          step_n   = (cfg_step == '0) ? DATA_W'(1) : DATA_W'(cfg_step);
`ifdef PWM_RAMP_PHASE_EN
          phase_n  = cfg_phase;
`endif
          duty_n   = '0;
          state_n  = LOAD;
        end
      end
      LOAD: state_n = SYNC;
      SYNC: begin
        if (stop) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (wrap) begin
          duty_n  = '0;
          state_n = (target_q == '0) ? HOLD : RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (stop) begin
          state_n = RAMP_DOWN;
        end else if (duty_q == target_q) begin
          state_n = HOLD;
        end else if (tick) begin
          duty_n = ((DATA_W+1)'(duty_q) + (DATA_W+1)'(step_q) > (DATA_W+1)'(target_q))
                   ? target_q : duty_q + step_q;
        end
      end
      HOLD: begin
        if (stop) state_n = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (duty_q == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (tick) begin
          duty_n = (duty_q > step_q) ? duty_q - step_q : '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Channel compares follow the next duty so they update on the wrap edge itself.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      s_n[k] = '0;
      p_n[k] = '0;
      if (!(state_n inside {IDLE, LOAD, SYNC})) begin
`ifdef PWM_RAMP_PHASE_EN
        s_n[k] = sat_mul(phase_n, 2'(k));
`endif
        p_n[k] = sat_add(s_n[k], duty_n);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      period_q <= '0;
      target_q <= '0;
      step_q   <= '0;
`ifdef PWM_RAMP_PHASE_EN
      phase_q  <= '0;
`endif
      load     <= 1'b0;
      d        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        s_q[k] <= '0;
        p_q[k] <= '0;
      end
    end else begin
      state_q  <= state_n;
      duty_q   <= duty_n;
      period_q <= period_n;
      target_q <= target_n;
      step_q   <= step_n;
`ifdef PWM_RAMP_PHASE_EN
      phase_q  <= phase_n;
`endif
      load     <= (state_n == LOAD);
      if (state_n == LOAD) d <= period_n;
      busy     <= (state_n != IDLE);
      done     <= done_n;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        s_q[k] <= s_n[k];
        p_q[k] <= p_n[k];
      end
    end
  end

  assign s0 = s_q[0];
  assign s1 = s_q[1];
  assign s2 = s_q[2];
  assign s3 = s_q[3];
  assign p0 = p_q[0];
  assign p1 = p_q[1];
  assign p2 = p_q[2];
  assign p3 = p_q[3];

endmodule
